// File: rtl/fractal_sync_cu_agent_if.sv
// Bundle of the per-channel command/completion handshakes and the fractal-sync
// leaf port seen by the compute-unit sync agent.
interface fractal_sync_cu_if #(
    parameter int N_CH   = 2,
    parameter int AGGR_W = 6,
    parameter int ID_W   = 5
) ();
    logic [N_CH-1:0]        cmd_valid_i;
    logic [N_CH-1:0]        cmd_ready_o;
    logic [N_CH*AGGR_W-1:0] cmd_aggr_i;
    logic [N_CH*ID_W-1:0]   cmd_id_i;
    logic [N_CH-1:0]        done_valid_o;
    logic [N_CH-1:0]        done_ready_i;
    logic [N_CH*2-1:0]      done_status_o;
    logic                   fsync_sync_o;
    logic [AGGR_W-1:0]      fsync_aggr_o;
    logic [ID_W-1:0]        fsync_id_o;
    logic                   fsync_wake_i;
    logic                   fsync_error_i;
    logic [ID_W-1:0]        fsync_id_rsp_i;

    modport master (
        output cmd_valid_i, cmd_aggr_i, cmd_id_i, done_ready_i,
               fsync_wake_i, fsync_error_i, fsync_id_rsp_i,
        input  cmd_ready_o, done_valid_o, done_status_o,
               fsync_sync_o, fsync_aggr_o, fsync_id_o
    );

    modport slave (
        input  cmd_valid_i, cmd_aggr_i, cmd_id_i, done_ready_i,
               fsync_wake_i, fsync_error_i, fsync_id_rsp_i,
        output cmd_ready_o, done_valid_o, done_status_o,
               fsync_sync_o, fsync_aggr_o, fsync_id_o
    );
endinterface

// File: rtl/fractal_sync_cu_agent.sv
// Compute-unit sync agent: per-channel barrier FSMs sharing one fractal-sync
// request port through a round-robin arbiter.
//
// state   | meaning
// IDLE    | accepting a new barrier command
// ISSUE   | command latched, requesting the sync port
// WAIT    | request sent, waiting for wake/error or timeout
// DONE    | completion status presented until accepted
module fractal_sync_cu_agent #(
    parameter int N_CH           = 2,
    parameter int AGGR_W         = 6,
    parameter int ID_W           = 5,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fractal_sync_cu_if.slave bus
);
    localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            r_state   [N_CH];
    state_t            w_state_nxt [N_CH];
    logic [AGGR_W-1:0] r_aggr    [N_CH];
    logic [AGGR_W-1:0] w_aggr_nxt [N_CH];
    logic [ID_W-1:0]   r_id      [N_CH];
    logic [ID_W-1:0]   w_id_nxt  [N_CH];
    logic [CW-1:0]     r_cnt     [N_CH];
    logic [CW-1:0]     w_cnt_nxt [N_CH];
    logic [1:0]        r_status  [N_CH];
    logic [1:0]        w_status_nxt [N_CH];
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     w_ptr_nxt;
    logic              w_gnt_vld;
    logic [PW-1:0]     w_gnt_idx;
    logic [N_CH-1:0]   w_cmd_ready;
    logic [N_CH-1:0]   w_done_valid;
    logic [N_CH*2-1:0] w_done_status;

    // Round-robin search starting at r_ptr; depends on registered state only.
    always_comb begin
        int idx;
        logic [PW-1:0] sel;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        idx       = 0;
        sel       = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            sel = PW'(idx);
            if (!w_gnt_vld && r_state[sel] == S_ISSUE) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = sel;
            end
        end
        w_ptr_nxt = r_ptr;
        if (w_gnt_vld) w_ptr_nxt = (int'(w_gnt_idx) == N_CH - 1) ? '0 : w_gnt_idx + PW'(1);
    end

    always_comb begin
        logic w_hit;
        w_hit = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            w_state_nxt[c]  = r_state[c];
            w_aggr_nxt[c]   = r_aggr[c];
            w_id_nxt[c]     = r_id[c];
            w_cnt_nxt[c]    = r_cnt[c];
            w_status_nxt[c] = r_status[c];
            w_hit = (bus.fsync_id_rsp_i == r_id[c]);
            case (r_state[c])
                S_IDLE: begin
                    if (bus.cmd_valid_i[c]) begin
                        w_aggr_nxt[c]   = bus.cmd_aggr_i[c*AGGR_W +: AGGR_W];
                        w_id_nxt[c]     = bus.cmd_id_i[c*ID_W +: ID_W];
                        w_cnt_nxt[c]    = '0;
                        w_status_nxt[c] = 2'b00;
                        w_state_nxt[c]  = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_gnt_vld && int'(w_gnt_idx) == c) begin
                        w_cnt_nxt[c]   = '0;
                        w_state_nxt[c] = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Matching responses take priority over the timeout.
                    if (bus.fsync_error_i && w_hit) begin
                        w_status_nxt[c] = 2'b01;
                        w_state_nxt[c]  = S_DONE;
                    end else if (bus.fsync_wake_i && w_hit) begin
                        w_status_nxt[c] = 2'b00;
                        w_state_nxt[c]  = S_DONE;
                    end else if (TIMEOUT_CYCLES != 0 && r_cnt[c] == TO_LAST) begin
                        w_status_nxt[c] = 2'b10;
                        w_state_nxt[c]  = S_DONE;
                    end else if (r_cnt[c] != CNT_MAX) begin
                        w_cnt_nxt[c] = r_cnt[c] + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.done_ready_i[c]) w_state_nxt[c] = S_IDLE;
                end
                default: w_state_nxt[c] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_state[c]  <= S_IDLE;
                r_aggr[c]   <= '0;
                r_id[c]     <= '0;
                r_cnt[c]    <= '0;
                r_status[c] <= 2'b00;
            end
        end else begin
            r_ptr <= w_ptr_nxt;
            for (int c = 0; c < N_CH; c++) begin
                r_state[c]  <= w_state_nxt[c];
                r_aggr[c]   <= w_aggr_nxt[c];
                r_id[c]     <= w_id_nxt[c];
                r_cnt[c]    <= w_cnt_nxt[c];
                r_status[c] <= w_status_nxt[c];
            end
        end
    end

    // Handshake outputs are held low for the whole reset cycle.
    always_comb begin
        w_cmd_ready   = '0;
        w_done_valid  = '0;
        w_done_status = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_cmd_ready[c]  = !rst_i && (r_state[c] == S_IDLE);
            w_done_valid[c] = !rst_i && (r_state[c] == S_DONE);
            if (!rst_i && r_state[c] == S_DONE) w_done_status[c*2 +: 2] = r_status[c];
        end
    end

    assign bus.cmd_ready_o   = w_cmd_ready;
    assign bus.done_valid_o  = w_done_valid;
    assign bus.done_status_o = w_done_status;
    assign bus.fsync_sync_o  = w_gnt_vld;
    assign bus.fsync_aggr_o  = w_gnt_vld ? r_aggr[w_gnt_idx] : '0;
    assign bus.fsync_id_o    = w_gnt_vld ? r_id[w_gnt_idx] : '0;
endmodule
